// File: rtl/rx_engine.sv
// UART receive engine: synchronizes rx, deframes start/data/parity/stop at mid-bit
// and presents the byte with rxrdy, parity, framing and overrun status.
module rx_engine #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] baud,
   input  logic       eight,
   input  logic       p_en,
   input  logic       ohel,
   input  logic       rx,
   input  logic       read_rx,
   output logic [7:0] rx_data,
   output logic       rxrdy,
   output logic       perr,
   output logic       ferr,
   output logic       ovf
);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   // Rounded clocks-per-bit for each rate select.
   function automatic logic [19:0] bit_count(input logic [3:0] sel);
      int rate;
      case (sel)
         4'd0:    rate = 300;
         4'd1:    rate = 1200;
         4'd2:    rate = 2400;
         4'd3:    rate = 4800;
         4'd4:    rate = 9600;
         4'd5:    rate = 19200;
         4'd6:    rate = 38400;
         4'd7:    rate = 57600;
         4'd8:    rate = 115200;
         4'd9:    rate = 230400;
         4'd10:   rate = 460800;
         default: rate = 921600;
      endcase
      return 20'((CLK_HZ + rate / 2) / rate);
   endfunction

   state_t      state, state_nxt;
   logic        rx_meta, rxs, rxs_d;
   logic [19:0] cnt, k_lat;
   logic        eight_lat, p_en_lat, ohel_lat;
   logic [7:0]  shreg;
   logic [2:0]  bit_idx;
   logic        par_bit;
   logic        start_edge, bit_end, half_hit, last_bit;
   logic [7:0]  data_asm;

   always_comb begin
      start_edge = rxs_d & ~rxs;
      bit_end    = (cnt == k_lat - 20'd1);
      half_hit   = (cnt == (k_lat >> 1));
      last_bit   = (bit_idx == (eight_lat ? 3'd7 : 3'd6));
      // In 7-bit mode only seven shifts happen, so the byte sits one place higher.
      data_asm   = eight_lat ? shreg : {1'b0, shreg[7:1]};
      state_nxt  = state;
      case (state)
         IDLE:    if (start_edge) state_nxt = START;
         START:   if (half_hit) state_nxt = rxs ? IDLE : DATA;
         DATA:    if (bit_end && last_bit) state_nxt = p_en_lat ? PAR : STOP;
         PAR:     if (bit_end) state_nxt = STOP;
         STOP:    if (bit_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         rxs_d     <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         k_lat     <= '0;
         eight_lat <= 1'b0;
         p_en_lat  <= 1'b0;
         ohel_lat  <= 1'b0;
         shreg     <= '0;
         bit_idx   <= '0;
         par_bit   <= 1'b0;
         rx_data   <= '0;
         rxrdy     <= 1'b0;
         perr      <= 1'b0;
         ferr      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
         state   <= state_nxt;
         if (state == IDLE || state_nxt != state || bit_end)
            cnt <= '0;
         else
            cnt <= cnt + 20'd1;
         case (state)
            IDLE: if (start_edge) begin
               k_lat     <= bit_count(baud);
               eight_lat <= eight;
               p_en_lat  <= p_en;
               ohel_lat  <= ohel;
            end
            START: bit_idx <= '0;
            DATA: if (bit_end) begin
               shreg   <= {rxs, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
            end
            PAR: if (bit_end) par_bit <= rxs;
            default: ;
         endcase
         // A completing frame takes priority over a simultaneous read strobe.
         if (state == STOP && bit_end) begin
            rx_data <= data_asm;
            ferr    <= ~rxs;
            perr    <= p_en_lat & (par_bit != (ohel_lat ? ~^data_asm : ^data_asm));
            ovf     <= (ovf | rxrdy) & ~read_rx;
            rxrdy   <= 1'b1;
         end else if (read_rx) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rx_engine.sv
// Self-checking bench for rx_engine: serial frames are generated from the framing
// rules and the expected status is tracked by a small scoreboard model.
module tb_rx_engine;

   logic       clk = 1'b0;
   logic       rst, eight, p_en, ohel, rx, read_rx;
   logic [3:0] baud;
   logic [7:0] rx_data;
   logic       rxrdy, perr, ferr, ovf;

   int checks = 0;
   int errors = 0;

   logic [7:0] mData;
   logic       mRdy, mPerr, mFerr, mOvf;

   always #5 clk = ~clk;

   rx_engine #(.CLK_HZ(100_000_000)) dut (
      .clk(clk), .rst(rst), .baud(baud), .eight(eight), .p_en(p_en), .ohel(ohel),
      .rx(rx), .read_rx(read_rx), .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr),
      .ferr(ferr), .ovf(ovf)
   );

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog timeout got=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int kOf(input int sel);
      real rate;
      case (sel)
         0: rate = 300.0;       1: rate = 1200.0;     2: rate = 2400.0;
         3: rate = 4800.0;      4: rate = 9600.0;     5: rate = 19200.0;
         6: rate = 38400.0;     7: rate = 57600.0;    8: rate = 115200.0;
         9: rate = 230400.0;    10: rate = 460800.0;
         default: rate = 921600.0;
      endcase
      return $rtoi(100.0e6 / rate + 0.5);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".rx_data"}, 32'(rx_data), 32'(mData));
      checkOutput({tag, ".rxrdy"}, 32'(rxrdy), 32'(mRdy));
      checkOutput({tag, ".perr"}, 32'(perr), 32'(mPerr));
      checkOutput({tag, ".ferr"}, 32'(ferr), 32'(mFerr));
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'(mOvf));
   endtask

   task automatic pulseRead();
      @(negedge clk) read_rx = 1'b1;
      @(negedge clk) read_rx = 1'b0;
      mRdy = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvf = 1'b0;
   endtask

   // Drives one complete frame on rx (scrambling the config inputs mid-frame) and
   // updates the scoreboard with what that frame should leave behind.
   task automatic applyStimulus(input logic [7:0] d, input int sel, input bit e8, input bit pe,
                                input bit odd, input bit parGood, input bit stopBit, input int tailLow);
      int k, nb, ones;
      bit p;
      k  = kOf(sel);
      nb = e8 ? 8 : 7;
      @(negedge clk);
      baud = 4'(sel); eight = e8; p_en = pe; ohel = odd;
      @(negedge clk) rx = 1'b0;
      repeat (k) @(negedge clk);
      baud = 4'($urandom); eight = 1'($urandom); p_en = 1'($urandom); ohel = 1'($urandom);
      ones = 0;
      for (int i = 0; i < nb; i++) begin
         rx = d[i];
         ones += int'(d[i]);
         repeat (k) @(negedge clk);
      end
      if (pe) begin
         p  = odd ? (ones % 2 == 0) : (ones % 2 == 1);
         rx = parGood ? p : ~p;
         repeat (k) @(negedge clk);
      end
      rx = stopBit;
      repeat (k) @(negedge clk);
      if (tailLow > 0) begin
         rx = 1'b0;
         repeat (tailLow) @(negedge clk);
      end
      rx = 1'b1;
      repeat (20) @(negedge clk);
      mData = e8 ? d : {1'b0, d[6:0]};
      mPerr = pe & ~parGood;
      mFerr = ~stopBit;
      mOvf  = mOvf | mRdy;
      mRdy  = 1'b1;
   endtask

   initial begin
      int offset, bound, k;
      bit found;
      logic [7:0] d;
      rst = 1'b1; rx = 1'b1; read_rx = 1'b0; baud = 4'd8; eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
      mData = '0; mRdy = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvf = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkAll("reset");

      applyStimulus(8'hA5, 8, 1, 0, 0, 1, 1, 0);
      checkAll("t1_8n1");

      pulseRead();
      applyStimulus(8'h03, 10, 1, 1, 1, 1, 1, 0);
      checkAll("t2_odd_ok");
      pulseRead();
      applyStimulus(8'h03, 10, 1, 1, 1, 0, 1, 0);
      checkAll("t2_odd_bad");

      pulseRead();
      applyStimulus(8'h7F, 10, 0, 1, 0, 1, 1, 0);
      checkAll("t3_7e1");
      pulseRead();
      applyStimulus(8'h55, 10, 0, 1, 0, 1, 0, 3 * kOf(10));
      checkAll("t3_break");

      pulseRead();
      applyStimulus(8'h11, 10, 1, 0, 0, 1, 1, 0);
      applyStimulus(8'h22, 10, 1, 0, 0, 1, 1, 0);
      checkAll("t4_overrun");
      pulseRead();
      checkAll("t4_read");

      @(negedge clk) baud = 4'd8;
      rx = 1'b0;
      repeat (300) @(negedge clk);
      rx = 1'b1;
      repeat (2 * kOf(8)) @(negedge clk);
      checkAll("t5_false_start");
      applyStimulus(8'h5A, 10, 1, 0, 0, 1, 1, 0);
      checkAll("t5_after_false");

      k = kOf(10);
      @(negedge clk) baud = 4'd10; eight = 1'b1; p_en = 1'b0;
      @(negedge clk) rx = 1'b0;
      repeat (k) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = (i % 2 == 0);
         repeat (k) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk) rst = 1'b0; rx = 1'b1;
      mData = '0; mRdy = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvf = 1'b0;
      repeat (3 * k) @(negedge clk);
      checkAll("t5_mid_rst");
      applyStimulus(8'h96, 10, 1, 0, 0, 1, 1, 0);
      checkAll("t5_after_rst");

      // Measure when rxrdy rises for a 0x3C frame, then strobe read_rx on that edge.
      pulseRead();
      bound  = 20 * k;
      found  = 1'b0;
      offset = bound;
      @(negedge clk);
      fork
         applyStimulus(8'h3C, 10, 1, 0, 0, 1, 1, 0);
         begin
            for (int i = 1; i <= bound && !found; i++) begin
               @(posedge clk) #1;
               if (rxrdy) begin
                  found  = 1'b1;
                  offset = i;
               end
            end
         end
      join
      checkOutput("t6_rdy_found", 32'(found), 32'd1);
      @(negedge clk);
      fork
         applyStimulus(8'h3C, 10, 1, 0, 0, 1, 1, 0);
         begin
            repeat (offset - 1) @(posedge clk);
            #1 read_rx = 1'b1;
            @(posedge clk) #1 read_rx = 1'b0;
         end
      join
      mOvf = 1'b0;
      mRdy = 1'b1;
      checkAll("t6_coincident_read");

      for (int n = 0; n < 16; n++) begin
         if ($urandom_range(0, 1) == 1) pulseRead();
         d = 8'($urandom);
         applyStimulus(d, $urandom_range(10, 15), 1'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 0);
         checkAll($sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
